uart_rx_os16: RTL and testbench

- UART receive stage that consumes the 16x-oversample rx tick from the baud generator and the raw serial line.
- Recovers asynchronous frames: 1 start bit, DATA_BITS data bits LSB first, no parity, 1 stop bit.
- Presents each received word with a single-cycle valid strobe to downstream logic (rx FIFO / command parser) and flags framing errors.

---
 rtl/uart_rx_os16.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16 - UART receiver driven by a 16x-oversample tick.
//
// Recovers 1 start bit, DATA_BITS data bits (LSB first), no parity and
// 1 stop bit. Each bit is decided by a 2-of-3 majority vote of the line
// sampled at oversample ticks 7, 8 and 9. Good frames update data_out with
// a one-clk data_valid strobe. A low stop bit gives a one-clk frame_err
// strobe and sends the receiver to HUNT until the line is seen idle again.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_tick    16x-oversample enable, one clk wide per tick (may be held high)
//   rx_in      asynchronous serial line, idle high
//   data_out   last good received word, held until the next good frame
//   data_valid one-clk pulse, data_out just updated
//   frame_err  one-clk pulse, stop bit voted low
//   busy       high while in START, DATA or STOP
module uart_rx_os16 #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        HUNT,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // Two-flop synchronizer; stage 0 samples the raw line.
    logic [1:0] sync_reg;
    logic       rx_s;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    sync_reg[gi] <= rx_in;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[1];

    state_t                 state_reg, state_next;
    logic [3:0]             tick_cnt_reg, tick_cnt_next;
    logic [2:0]             bit_idx_reg, bit_idx_next;
    logic                   samp7_reg, samp7_next;
    logic                   samp8_reg, samp8_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   data_out_reg, data_out_next;
    logic                   data_valid_reg, data_valid_next;
    logic                   frame_err_reg, frame_err_next;
    logic                   busy_reg, busy_next;
    logic                   vote;
    logic                   in_frame;

    // Majority of the two stored samples and the live sample at tick 9.
    assign vote = (samp7_reg & samp8_reg) | (samp7_reg & rx_s) | (samp8_reg & rx_s);
    assign in_frame = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);

    always_comb begin
        state_next      = state_reg;
        tick_cnt_next   = tick_cnt_reg;
        bit_idx_next    = bit_idx_reg;
        samp7_next      = samp7_reg;
        samp8_next      = samp8_reg;
        shift_next      = shift_reg;
        data_out_next   = data_out_reg;
        data_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        if (rx_tick) begin
            if (in_frame) begin
                tick_cnt_next = tick_cnt_reg + 4'd1;
                if (tick_cnt_reg == 4'd7) begin
                    samp7_next = rx_s;
                end
                if (tick_cnt_reg == 4'd8) begin
                    samp8_next = rx_s;
                end
            end

            case (state_reg)
                HUNT: begin
                    tick_cnt_next = 4'd0;
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end
                IDLE: begin
                    tick_cnt_next = 4'd0;
                    if (!rx_s) begin
                        // The detection tick is tick 0 of the start bit.
                        state_next    = START;
                        tick_cnt_next = 4'd1;
                    end
                end
                START: begin
                    if (tick_cnt_reg == 4'd9 && vote) begin
                        state_next    = IDLE;
                        tick_cnt_next = 4'd0;
                    end else if (tick_cnt_reg == 4'd15) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                    end
                end
                DATA: begin
                    if (tick_cnt_reg == 4'd9) begin
                        shift_next = {vote, shift_reg[DATA_BITS-1:1]};
                    end
                    if (tick_cnt_reg == 4'd15) begin
                        if (bit_idx_reg == LAST_BIT) begin
                            state_next = STOP;
                        end else begin
                            bit_idx_next = bit_idx_reg + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Decide at mid-stop so the next start edge is caught early.
                    if (tick_cnt_reg == 4'd9) begin
                        tick_cnt_next = 4'd0;
                        if (vote) begin
                            data_out_next   = shift_reg;
                            data_valid_next = 1'b1;
                            state_next      = IDLE;
                        end else begin
                            frame_err_next = 1'b1;
                            state_next     = HUNT;
                        end
                    end
                end
                default: begin
                    state_next    = HUNT;
                    tick_cnt_next = 4'd0;
                end
            endcase
        end

        busy_next = (state_next == START) || (state_next == DATA) || (state_next == STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= HUNT;
            tick_cnt_reg   <= 4'd0;
            bit_idx_reg    <= 3'd0;
            samp7_reg      <= 1'b1;
            samp8_reg      <= 1'b1;
            shift_reg      <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            samp7_reg      <= samp7_next;
            samp8_reg      <= samp8_next;
            shift_reg      <= shift_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
            busy_reg       <= busy_next;
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16 - directed self-checking bench for uart_rx_os16.
// Expected words/errors are queued when a frame is sent; a negedge monitor
// queues every observed valid/error strobe; the two queues are compared.
module tb_uart_rx_os16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_tick = 1'b0;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_os16 #(.DATA_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_tick    (rx_tick),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tick_div   = 1;
    int tick_phase = 0;
    int cyc        = 0;

    always @(negedge clk) begin
        tick_phase = (tick_phase + 1) % tick_div;
        rx_tick    = (tick_phase == 0);
    end

    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic       err;
        logic       both;
        logic [7:0] data;
        int         at_cyc;
    } obs_t;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];

    always @(negedge clk) begin : monitor
        obs_t o;
        if (data_valid === 1'b1 || frame_err === 1'b1) begin
            o.err    = frame_err;
            o.both   = data_valid & frame_err;
            o.data   = data_out;
            o.at_cyc = cyc;
            obs_q.push_back(o);
        end
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       busy_low;
    logic [7:0] last_good;
    int         frame_start_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (rx_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic v, input logic glitch);
        rx_in = v;
        wait_ticks(8);
        if (busy !== 1'b1) busy_low = 1'b1;
        if (glitch) begin
            rx_in = ~v;
            wait_ticks(1);
            rx_in = v;
            wait_ticks(7);
        end else begin
            wait_ticks(8);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic glitch);
        busy_low        = 1'b0;
        frame_start_cyc = cyc;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit(stop_v, 1'b0);
        chk("busy_in_frame", {31'd0, busy_low}, 32'd0);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_word(input logic [7:0] d);
        exp_t e;
        e.err  = 1'b0;
        e.data = d;
        exp_q.push_back(e);
        last_good = d;
    endtask

    task automatic expect_err();
        exp_t e;
        e.err  = 1'b1;
        e.data = last_good;
        exp_q.push_back(e);
    endtask

    task automatic check_events(input string tag);
        obs_t o;
        exp_t e;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_kind"}, {31'd0, o.err}, {31'd0, e.err});
            chk({tag, "_data"}, {24'd0, o.data}, {24'd0, e.data});
            chk({tag, "_both"}, {31'd0, o.both}, 32'd0);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        last_good = 8'h00;
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_data_out", {24'd0, data_out}, 32'h0);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_ticks(20);

        // Single frame, tick every clk; valid near mid-stop (~9.5 bits + pipeline).
        expect_word(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        lat = -1;
        if (obs_q.size() > 0) lat = obs_q[0].at_cyc - frame_start_cyc;
        n_checks++;
        assert (lat >= 150 && lat <= 160) else begin
            n_fail++;
            $error("FAIL valid_latency: observed %0d expected 150..160", lat);
        end
        wait_ticks(4);
        check_events("f55");
        chk("f55_hold", {24'd0, data_out}, 32'h55);

        // Back-to-back frames.
        expect_word(8'hA3);
        expect_word(8'h3C);
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_ticks(4);
        check_events("b2b");
        chk("b2b_hold", {24'd0, data_out}, 32'h3C);

        // Short low glitch rejected by the start-bit vote.
        rx_in = 1'b0;
        wait_ticks(3);
        chk("glitch_busy_up", {31'd0, busy}, 32'd1);
        rx_in = 1'b1;
        wait_ticks(10);
        chk("glitch_busy_down", {31'd0, busy}, 32'd0);
        wait_ticks(6);
        check_events("glitch");
        expect_word(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(4);
        check_events("f81");

        // Framing error, then a held-low line must not start a frame.
        expect_err();
        send_frame(8'hF0, 1'b0, 1'b0);
        wait_ticks(40);
        chk("hunt_busy", {31'd0, busy}, 32'd0);
        chk("ferr_hold", {24'd0, data_out}, 32'h81);
        rx_in = 1'b1;
        wait_ticks(16);
        check_events("ferr");
        expect_word(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        wait_ticks(4);
        check_events("f12");

        // One-tick glitches inside every data bit.
        expect_word(8'h6B);
        send_frame(8'h6B, 1'b1, 1'b1);
        wait_ticks(4);
        check_events("vote");

        // Sparse ticks, then reset in the middle of a frame with the line low.
        tick_div = 4;
        wait_ticks(16);
        expect_word(8'hFF);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_ticks(4);
        check_events("fff");
        rx_in = 1'b0;
        wait_ticks(16 + 3 * 16 + 8);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        wait_ticks(1);
        rst = 1'b0;
        chk("mid_rst_data", {24'd0, data_out}, 32'h0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        wait_ticks(20);
        chk("low_after_rst_busy", {31'd0, busy}, 32'd0);
        rx_in = 1'b1;
        wait_ticks(16);
        check_events("rst_quiet");
        last_good = 8'h00;
        expect_word(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_ticks(4);
        check_events("f5a");
        chk("f5a_hold", {24'd0, data_out}, 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
